// File: rtl/game_pkg.sv
// Shared air-hockey table geometry, fixed-point widths, puck state and the
// small arithmetic helpers used by the puck controller.
package game_pkg;
  localparam int RADIUS_BALL    = 10;
  localparam int PLAYERS_RADIUS = 20;
  localparam int X_MIN          = 43;
  localparam int X_MAX          = 980;
  localparam int Y_MIN          = 43;
  localparam int Y_MAX          = 726;
  localparam int GOAL_Y_MIN     = 265;
  localparam int GOAL_Y_MAX     = 451;
  localparam int CENTER_X       = 487;
  localparam int CENTER_Y       = 362;
  localparam int FRAC_BITS      = 8;
  localparam int COORD_W        = 12;
  localparam int POS_W          = COORD_W + FRAC_BITS;
  localparam int VEL_W          = 13 + FRAC_BITS;
  localparam int NUM_PADDLES    = 2;

  typedef logic [COORD_W-1:0] coord_t;

  // Centre-position limits: the puck edge touches a wall at these values.
  localparam coord_t X_LO  = coord_t'(X_MIN + RADIUS_BALL);
  localparam coord_t X_HI  = coord_t'(X_MAX - RADIUS_BALL);
  localparam coord_t Y_LO  = coord_t'(Y_MIN + RADIUS_BALL);
  localparam coord_t Y_HI  = coord_t'(Y_MAX - RADIUS_BALL);
  localparam coord_t GY_LO = coord_t'(GOAL_Y_MIN + RADIUS_BALL);
  localparam coord_t GY_HI = coord_t'(GOAL_Y_MAX - RADIUS_BALL);

  typedef enum logic [1:0] {SERVE, PLAY, GOAL, OVER} state_t;

  typedef struct packed {
    logic [POS_W-1:0]        x;
    logic [POS_W-1:0]        y;
    logic signed [VEL_W-1:0] vx;
    logic signed [VEL_W-1:0] vy;
  } ball_t;

  function automatic logic [POS_W-1:0] to_fix(input coord_t c);
    return {c, {FRAC_BITS{1'b0}}};
  endfunction

  function automatic logic signed [VEL_W-1:0] clamp_vel(input logic signed [29:0] v,
                                                        input int vmax);
    logic signed [29:0] lim, r;
    lim = 30'(vmax);
    r   = v;
    if (v > lim)       r = lim;
    else if (v < -lim) r = -lim;
    return r[VEL_W-1:0];
  endfunction

  // Decay on the magnitude so small negative speeds hold just like positive ones.
  function automatic logic signed [VEL_W-1:0] fric(input logic signed [VEL_W-1:0] v,
                                                   input int sh);
    logic [VEL_W-1:0] mag, d;
    mag = v[VEL_W-1] ? -v : v;
    d   = mag >> sh;
    return v[VEL_W-1] ? v + $signed(d) : v - $signed(d);
  endfunction

  function automatic logic [POS_W-1:0] integ(input logic [POS_W-1:0] p,
                                             input logic signed [VEL_W-1:0] v,
                                             input coord_t lo, input coord_t hi);
    logic signed [POS_W+2:0] s, lo_f, hi_f;
    s    = $signed({3'b000, p}) + (POS_W+3)'(v);
    lo_f = $signed({3'b000, to_fix(lo)});
    hi_f = $signed({3'b000, to_fix(hi)});
    if (s < lo_f)      return to_fix(lo);
    else if (s > hi_f) return to_fix(hi);
    return s[POS_W-1:0];
  endfunction
endpackage

// File: rtl/paddle_collide.sv
// Combinational puck/paddle overlap test and the clamped velocity a hit imparts.
module paddle_collide
  import game_pkg::*;
#(
  parameter int HIT_SHIFT = 6,
  parameter int V_MAX     = 2048
) (
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  input  logic [COORD_W-1:0] pad_x,
  input  logic [COORD_W-1:0] pad_y,
  output logic               hit,
  output logic signed [VEL_W-1:0] hit_vx,
  output logic signed [VEL_W-1:0] hit_vy
);
  localparam int HIT_R = RADIUS_BALL + PLAYERS_RADIUS;

  logic signed [COORD_W:0]     dx, dy;
  logic signed [2*COORD_W+1:0] dx2, dy2;
  logic signed [2*COORD_W+2:0] dist2;

  assign dx    = $signed({1'b0, ball_x}) - $signed({1'b0, pad_x});
  assign dy    = $signed({1'b0, ball_y}) - $signed({1'b0, pad_y});
  assign dx2   = (2*COORD_W+2)'(dx) * (2*COORD_W+2)'(dx);
  assign dy2   = (2*COORD_W+2)'(dy) * (2*COORD_W+2)'(dy);
  assign dist2 = (2*COORD_W+3)'(dx2) + (2*COORD_W+3)'(dy2);
  assign hit   = dist2 < (2*COORD_W+3)'(HIT_R * HIT_R);

  assign hit_vx = clamp_vel(30'(dx) <<< HIT_SHIFT, V_MAX);
  assign hit_vy = clamp_vel(30'(dy) <<< HIT_SHIFT, V_MAX);
endmodule

// File: rtl/puck_physics_ctl.sv
// Air-hockey puck controller: per-frame physics, goals, post-goal pause and
// match scoring between the paddle sources and the drawing blocks.
module puck_physics_ctl
  import game_pkg::*;
#(
  parameter int HIT_SHIFT      = 6,
  parameter int V_MAX          = 2048,
  parameter int FRICTION_SHIFT = 6,
  parameter int GOAL_PAUSE     = 60,
  parameter int MAX_SCORE      = 7,
  parameter int SCORE_W        = 5
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start,
  input  logic [11:0]        xpos_player_1,
  input  logic [11:0]        ypos_player_1,
  input  logic [11:0]        xpos_player_2,
  input  logic [11:0]        ypos_player_2,
  output logic [11:0]        xpos_ball,
  output logic [11:0]        ypos_ball,
  output logic [SCORE_W-1:0] player_1_score,
  output logic [SCORE_W-1:0] player_2_score,
  output logic               goal,
  output logic               goal_side,
  output logic               game_over
);
  localparam int PAUSE_W = $clog2(GOAL_PAUSE + 1);
  localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(GOAL_PAUSE - 1);
  localparam logic [SCORE_W-1:0] SCORE_TOP  = SCORE_W'(MAX_SCORE);
  localparam ball_t BALL_HOME = '{x: to_fix(coord_t'(CENTER_X)), y: to_fix(coord_t'(CENTER_Y)),
                                  vx: '0, vy: '0};

  state_t              state_q, state_d;
  ball_t               ball_q, ball_d;
  logic [SCORE_W-1:0]  s1_q, s1_d, s2_q, s2_d;
  logic                goal_q, goal_d, side_q, side_d;
  logic [PAUSE_W-1:0]  cnt_q, cnt_d;

  coord_t bx, by;
  assign bx = ball_q.x[POS_W-1:FRAC_BITS];
  assign by = ball_q.y[POS_W-1:FRAC_BITS];

  // Index 0 is paddle 1 so a priority pick on the lowest index favours it.
  logic [NUM_PADDLES-1:0][COORD_W-1:0] pad_x, pad_y;
  logic [NUM_PADDLES-1:0]              pad_hit;
  logic [NUM_PADDLES-1:0][VEL_W-1:0]   pad_vx, pad_vy;
  assign pad_x = {xpos_player_2, xpos_player_1};
  assign pad_y = {ypos_player_2, ypos_player_1};

  for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_pad
    paddle_collide #(.HIT_SHIFT(HIT_SHIFT), .V_MAX(V_MAX)) u_collide (
      .ball_x(bx), .ball_y(by), .pad_x(pad_x[i]), .pad_y(pad_y[i]),
      .hit(pad_hit[i]), .hit_vx(pad_vx[i]), .hit_vy(pad_vy[i])
    );
  end

  logic in_mouth, at_l, at_r, wall_l, wall_r, wall_t, wall_b;
  assign in_mouth = (by > GY_LO) && (by < GY_HI);
  assign at_l     = bx <= X_LO;
  assign at_r     = bx >= X_HI;
  // Reflect only while moving into the wall, so a clamped puck never bounces twice.
  assign wall_l   = at_l && ball_q.vx[VEL_W-1];
  assign wall_r   = at_r && !ball_q.vx[VEL_W-1] && (ball_q.vx != '0);
  assign wall_t   = (by <= Y_LO) && ball_q.vy[VEL_W-1];
  assign wall_b   = (by >= Y_HI) && !ball_q.vy[VEL_W-1] && (ball_q.vy != '0);

  logic signed [VEL_W-1:0] nvx, nvy;
  logic [POS_W-1:0]        px, py;

  always_comb begin
    state_d = state_q;
    ball_d  = ball_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    goal_d  = 1'b0;
    side_d  = side_q;
    cnt_d   = cnt_q;
    nvx     = ball_q.vx;
    nvy     = ball_q.vy;
    px      = ball_q.x;
    py      = ball_q.y;
    case (state_q)
      SERVE: begin
        ball_d = BALL_HOME;
        if (start) state_d = PLAY;
      end
      PLAY: if (frame_tick) begin
        if ((at_l || at_r) && in_mouth) begin
          ball_d  = BALL_HOME;
          cnt_d   = '0;
          goal_d  = 1'b1;
          side_d  = !at_l;
          state_d = GOAL;
          if (at_l) s2_d = (s2_q < SCORE_TOP) ? s2_q + 1'b1 : s2_q;
          else      s1_d = (s1_q < SCORE_TOP) ? s1_q + 1'b1 : s1_q;
        end else begin
          if (wall_l || wall_r || wall_t || wall_b) begin
            if (wall_l) begin nvx = -ball_q.vx; px = to_fix(X_LO); end
            if (wall_r) begin nvx = -ball_q.vx; px = to_fix(X_HI); end
            if (wall_t) begin nvy = -ball_q.vy; py = to_fix(Y_LO); end
            if (wall_b) begin nvy = -ball_q.vy; py = to_fix(Y_HI); end
          end else if (pad_hit[0]) begin
            nvx = $signed(pad_vx[0]);
            nvy = $signed(pad_vy[0]);
          end else if (pad_hit[1]) begin
            nvx = $signed(pad_vx[1]);
            nvy = $signed(pad_vy[1]);
          end else begin
            nvx = fric(ball_q.vx, FRICTION_SHIFT);
            nvy = fric(ball_q.vy, FRICTION_SHIFT);
          end
          ball_d.vx = nvx;
          ball_d.vy = nvy;
          ball_d.x  = integ(px, nvx, X_LO, X_HI);
          ball_d.y  = integ(py, nvy, Y_LO, Y_HI);
        end
      end
      GOAL: begin
        ball_d = BALL_HOME;
        if (frame_tick) begin
          if (cnt_q == PAUSE_LAST) begin
            cnt_d   = '0;
            state_d = (s1_q == SCORE_TOP || s2_q == SCORE_TOP) ? OVER : PLAY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      OVER: begin
        ball_d = BALL_HOME;
        if (start) begin
          s1_d    = '0;
          s2_d    = '0;
          state_d = SERVE;
        end
      end
      default: state_d = SERVE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SERVE;
      ball_q  <= BALL_HOME;
      s1_q    <= '0;
      s2_q    <= '0;
      goal_q  <= 1'b0;
      side_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ball_q  <= ball_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      goal_q  <= goal_d;
      side_q  <= side_d;
      cnt_q   <= cnt_d;
    end
  end

  assign xpos_ball      = bx;
  assign ypos_ball      = by;
  assign player_1_score = s1_q;
  assign player_2_score = s2_q;
  assign goal           = goal_q;
  assign goal_side      = side_q;
  assign game_over      = (state_q == OVER);
endmodule

// File: tb/tb_puck_physics_ctl.sv
// Directed bench for puck_physics_ctl plus direct checks of the hit-velocity clamp.
module tb_puck_physics_ctl;
  import game_pkg::*;

  logic        clk_in = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, start = 1'b0;
  logic [11:0] xp1 = 12'd4000, yp1 = 12'd4000, xp2 = 12'd4000, yp2 = 12'd4000;
  logic [11:0] xpos_ball, ypos_ball;
  logic [4:0]  s1, s2;
  logic        goal, goal_side, game_over;

  logic [11:0] cb_x = '0, cb_y = '0, cp_x = '0, cp_y = '0;
  logic        c6_hit, c7_hit;
  logic signed [VEL_W-1:0] c6_vx, c6_vy, c7_vx, c7_vy;

  int   n_pass = 0, n_chk = 0;
  logic goal_q = 1'b0, side_q = 1'b0;

  always #5 clk_in = ~clk_in;

  puck_physics_ctl dut (
    .clk_in(clk_in), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .xpos_player_1(xp1), .ypos_player_1(yp1), .xpos_player_2(xp2), .ypos_player_2(yp2),
    .xpos_ball(xpos_ball), .ypos_ball(ypos_ball),
    .player_1_score(s1), .player_2_score(s2),
    .goal(goal), .goal_side(goal_side), .game_over(game_over)
  );

  paddle_collide #(.HIT_SHIFT(6), .V_MAX(2048)) u_clamp6 (
    .ball_x(cb_x), .ball_y(cb_y), .pad_x(cp_x), .pad_y(cp_y),
    .hit(c6_hit), .hit_vx(c6_vx), .hit_vy(c6_vy));
  paddle_collide #(.HIT_SHIFT(7), .V_MAX(2048)) u_clamp7 (
    .ball_x(cb_x), .ball_y(cb_y), .pad_x(cp_x), .pad_y(cp_y),
    .hit(c7_hit), .hit_vx(c7_vx), .hit_vy(c7_vy));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, $signed(got), $signed(exp));
  endtask

  task automatic tick();
    @(negedge clk_in) frame_tick = 1'b1;
    @(negedge clk_in) frame_tick = 1'b0;
    goal_q = goal;
    side_q = goal_side;
  endtask

  task automatic pulse_start();
    @(negedge clk_in) start = 1'b1;
    @(negedge clk_in) start = 1'b0;
  endtask

  task automatic place1(input logic [11:0] x, input logic [11:0] y);
    xp1 = x; yp1 = y;
  endtask

  task automatic park();
    xp1 = 12'd4000; yp1 = 12'd4000; xp2 = 12'd4000; yp2 = 12'd4000;
  endtask

  task automatic do_reset();
    park();
    @(negedge clk_in) rst_n = 1'b0;
    @(negedge clk_in) rst_n = 1'b1;
  endtask

  task automatic wait_goal(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (goal_q) seen = 1'b1;
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    int xmin, ymin, goals_ok;
    bit x_hit, x_up, y_hit, y_up, any_goal;

    // Hit-velocity clamp and the strict overlap boundary
    cb_x = 12'd457; cb_y = 12'd362; cp_x = 12'd487; cp_y = 12'd362;
    #1;
    chk("edge_no_hit", 32'(c6_hit), 0);
    chk("vx_shift6", 32'(c6_vx), -1920);
    chk("vy_shift6", 32'(c6_vy), 0);
    chk("vx_shift7_clamp", 32'(c7_vx), -2048);
    cp_x = 12'd486;
    #1;
    chk("inside_hit", 32'(c7_hit), 1);
    cp_x = 12'd427;
    #1;
    chk("vx_shift7_clamp_pos", 32'(c7_vx), 2048);

    // Reset state
    repeat (3) @(negedge clk_in);
    chk("rst_x", xpos_ball, 487);
    chk("rst_y", ypos_ball, 362);
    chk("rst_s1", s1, 0);
    chk("rst_s2", s2, 0);
    chk("rst_goal", goal, 0);
    chk("rst_side", goal_side, 0);
    chk("rst_over", game_over, 0);
    @(negedge clk_in) rst_n = 1'b1;

    // SERVE ignores ticks; start+tick together only transitions
    place1(12'd467, 12'd362);
    tick();
    chk("serve_hold_x", xpos_ball, 487);
    @(negedge clk_in) begin start = 1'b1; frame_tick = 1'b1; end
    @(negedge clk_in) begin start = 1'b0; frame_tick = 1'b0; end
    chk("start_tick_x", xpos_ball, 487);
    tick();
    chk("hit_x", xpos_ball, 492);
    chk("hit_y", ypos_ball, 362);
    park();
    pulse_start();
    tick();
    chk("friction_x", xpos_ball, 496);

    // Asynchronous reset mid-PLAY
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_x", xpos_ball, 487);
    chk("async_rst_y", ypos_ball, 362);
    @(negedge clk_in) rst_n = 1'b1;

    // Both paddles overlapping: paddle 1 wins
    pulse_start();
    place1(12'd467, 12'd362);
    xp2 = 12'd487; yp2 = 12'd342;
    tick();
    chk("both_x", xpos_ball, 492);
    chk("both_y", ypos_ball, 362);

    // Left goal, one-cycle pulse, 60-tick pause
    do_reset();
    pulse_start();
    place1(12'd516, 12'd362);
    tick();
    chk("left_hit_x", xpos_ball, 479);
    park();
    wait_goal(3000, seen);
    chk("left_goal_seen", 32'(seen), 1);
    chk("left_side", 32'(side_q), 0);
    chk("left_s2", s2, 1);
    chk("left_s1", s1, 0);
    chk("left_home_x", xpos_ball, 487);
    @(negedge clk_in);
    chk("goal_one_cycle", goal, 0);
    place1(12'd467, 12'd362);
    repeat (60) tick();
    chk("pause_frozen_x", xpos_ball, 487);
    tick();
    chk("resume_hit_x", xpos_ball, 492);

    // Diagonal run: top wall bounce, then left wall bounce outside goal mouth
    do_reset();
    pulse_start();
    place1(12'd508, 12'd383);
    tick();
    chk("diag_x", xpos_ball, 481);
    chk("diag_y", ypos_ball, 356);
    park();
    xmin = 4095; ymin = 4095;
    x_hit = 0; x_up = 0; y_hit = 0; y_up = 0; any_goal = 0;
    for (int i = 0; i < 4000 && !x_up; i++) begin
      tick();
      if (goal_q) any_goal = 1;
      if (int'(xpos_ball) < xmin) xmin = int'(xpos_ball);
      if (int'(ypos_ball) < ymin) ymin = int'(ypos_ball);
      if (ypos_ball == 12'd53) y_hit = 1;
      if (y_hit && ypos_ball > 12'd53) y_up = 1;
      if (xpos_ball == 12'd53) x_hit = 1;
      if (x_hit && xpos_ball > 12'd53) x_up = 1;
    end
    chk("top_clamp_min_y", 32'(ymin), 53);
    chk("top_reflect", 32'(y_up), 1);
    chk("left_clamp_min_x", 32'(xmin), 53);
    chk("left_reflect", 32'(x_up), 1);
    chk("wall_no_goal", 32'(any_goal), 0);
    chk("wall_s2", s2, 0);

    // Seven right goals end the match
    do_reset();
    pulse_start();
    goals_ok = 0;
    for (int g = 0; g < 7; g++) begin
      if (g > 0) repeat (60) tick();
      place1(12'd458, 12'd362);
      tick();
      park();
      wait_goal(3000, seen);
      if (seen && side_q) goals_ok++;
    end
    chk("right_goals", 32'(goals_ok), 7);
    chk("final_s1", s1, 7);
    chk("final_s2", s2, 0);
    chk("pause_not_over", game_over, 0);
    repeat (60) tick();
    chk("game_over", game_over, 1);
    chk("over_home_x", xpos_ball, 487);
    chk("over_s1_sat", s1, 7);
    pulse_start();
    chk("restart_s1", s1, 0);
    chk("restart_over", game_over, 0);
    place1(12'd467, 12'd362);
    tick();
    chk("restart_serve_x", xpos_ball, 487);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
